// File: rtl/disp_pkg.sv
// Shared display-path definitions: BCD sign/blank codes and the
// BCD-to-binary converter state type.
package disp_pkg;

   localparam logic [3:0] BCD_MINUS = 4'b1010;
   localparam logic [3:0] BCD_BLANK = 4'b1111;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      FINISH
   } bcd2bin_state_t;

endpackage

// File: rtl/bcd2bin_seq_if.sv
// Start/done handshake and data bus of the sequential BCD-to-binary
// converter; the requester uses master, the converter uses slave.
interface bcd2bin_seq_if #(
   parameter int width  = 6,
   parameter int digits = 2
) ();

   logic                  start;
   logic [digits*4-1:0]   bcd;
   logic [3:0]            bcd_sgn;
   logic                  busy;
   logic                  done;
   logic [width-1:0]      bin;
   logic                  err;

   modport master (
      output start, bcd, bcd_sgn,
      input  busy, done, bin, err
   );

   modport slave (
      input  start, bcd, bcd_sgn,
      output busy, done, bin, err
   );

endinterface

// File: rtl/bcd_digit_adj.sv
// Reverse double-dabble digit correction: a nibble of 8 or more
// had a borrowed ten shifted into it, so take 3 back off.
module bcd_digit_adj (
   input  logic [3:0] nibble,
   output logic [3:0] adjusted
);

   assign adjusted = (nibble >= 4'd8) ? (nibble - 4'd3) : nibble;

endmodule

// File: rtl/bcd2bin_seq.sv
// Sequential BCD-to-binary converter, one reverse double-dabble bit per clock.
// Define BCD2BIN_SAT_EN to saturate bin on err instead of forcing it to zero.
module bcd2bin_seq
   import disp_pkg::*;
#(
   parameter int width   = 6,
   parameter int digits  = 2,
   parameter int abs_val = 1
) (
   input  logic          clk,
   input  logic          rst,
   bcd2bin_seq_if.slave  bus
);

   localparam int bcd_width  = digits * 4;
   localparam int work_width = bcd_width + width;
   localparam int cnt_width  = $clog2(width + 1);

   localparam logic [cnt_width-1:0] last_shift = cnt_width'(width - 1);
   localparam logic [width-1:0]     pos_max    = {1'b0, {(width-1){1'b1}}};
   localparam logic [width-1:0]     neg_max    = {1'b1, {(width-1){1'b0}}};

   bcd2bin_state_t         state;
   logic [work_width-1:0]  work;
   logic [work_width-1:0]  shifted;
   logic [work_width-1:0]  corrected;
   logic [cnt_width-1:0]   cnt;
   logic                   neg;
   logic                   bad_digit;
   logic                   bad_in;
   logic                   busy_q;
   logic                   done_q;
   logic [width-1:0]       bin_q;
   logic                   err_q;

   logic [width-1:0]       mag;
   logic [bcd_width-1:0]   residue;
   logic                   overflow;
   logic                   err_next;
   logic [width-1:0]       bin_next;

   assign shifted = work >> 1;
   assign corrected[width-1:0] = shifted[width-1:0];

   for (genvar i = 0; i < digits; i++) begin : g_adj
      bcd_digit_adj u_adj (
         .nibble   (shifted[width + 4*i +: 4]),
         .adjusted (corrected[width + 4*i +: 4])
      );
   end

   always_comb begin
      bad_in = 1'b0;
      for (int i = 0; i < digits; i++) begin
         if (bus.bcd[4*i +: 4] > 4'd9) bad_in = 1'b1;
      end
   end

   // Any BCD left above the binary field means the value did not fit in width bits.
   always_comb begin
      mag      = work[width-1:0];
      residue  = work[work_width-1:width];
      overflow = |residue;
      if (abs_val != 0) begin
         if (neg) overflow = overflow | (mag > neg_max);
         else     overflow = overflow | (mag > pos_max);
      end
      err_next = bad_digit | overflow;
      bin_next = '0;
      if (err_next) begin
`ifdef BCD2BIN_SAT_EN
         if (bad_digit)          bin_next = '0;
         else if (neg)           bin_next = neg_max;
         else if (abs_val != 0)  bin_next = pos_max;
         else                    bin_next = '1;
`else
         bin_next = '0;
`endif
      end else begin
         bin_next = neg ? ('0 - mag) : mag;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         work      <= '0;
         cnt       <= '0;
         neg       <= 1'b0;
         bad_digit <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         bin_q     <= '0;
         err_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  work      <= {bus.bcd, {width{1'b0}}};
                  neg       <= (abs_val != 0) && (bus.bcd_sgn == BCD_MINUS);
                  bad_digit <= bad_in;
                  cnt       <= '0;
                  busy_q    <= 1'b1;
                  state     <= SHIFT;
               end
            end
            SHIFT: begin
               // The last shift lands the final binary bit; correcting after it would corrupt the residue.
               work <= (cnt == last_shift) ? shifted : corrected;
               cnt  <= cnt + 1'b1;
               if (cnt == last_shift) state <= FINISH;
            end
            FINISH: begin
               bin_q  <= bin_next;
               err_q  <= err_next;
               done_q <= 1'b1;
               busy_q <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.bin  = bin_q;
   assign bus.err  = err_q;

endmodule

// File: tb/tb_bcd2bin_seq.sv
// Randomised and directed bench for bcd2bin_seq: a signed and an unsigned
// instance checked against an arithmetic model of BCD decoding.
module tb_bcd2bin_seq;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clk = ~clk;

   bcd2bin_seq_if #(.width(6), .digits(2)) s_if ();
   bcd2bin_seq_if #(.width(6), .digits(2)) u_if ();

   bcd2bin_seq #(.width(6), .digits(2), .abs_val(1)) dut_s (
      .clk (clk),
      .rst (rst),
      .bus (s_if.slave)
   );

   bcd2bin_seq #(.width(6), .digits(2), .abs_val(0)) dut_u (
      .clk (clk),
      .rst (rst),
      .bus (u_if.slave)
   );

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // Decimal value of the digits, then range rules for the chosen signedness.
   function automatic void model(input bit uns, input logic [7:0] b, input logic [3:0] s,
                                 output logic [5:0] eb, output logic ee);
      int v;
      bit bad, neg, ovf;
      v   = int'(b[7:4]) * 10 + int'(b[3:0]);
      bad = (b[7:4] > 4'd9) || (b[3:0] > 4'd9);
      neg = !uns && (s == 4'hA);
      if (uns)      ovf = v > 63;
      else if (neg) ovf = v > 32;
      else          ovf = v > 31;
      ee = bad || ovf;
      if (ee) begin
`ifdef BCD2BIN_SAT_EN
         if (bad)      eb = 6'd0;
         else if (neg) eb = 6'b100000;
         else if (uns) eb = 6'b111111;
         else          eb = 6'b011111;
`else
         eb = 6'd0;
`endif
      end else begin
         eb = neg ? 6'((64 - v) % 64) : 6'(v);
      end
   endfunction

   task automatic drive(input bit uns, input logic st, input logic [7:0] b, input logic [3:0] s);
      if (uns) begin
         u_if.start = st; u_if.bcd = b; u_if.bcd_sgn = s;
      end else begin
         s_if.start = st; s_if.bcd = b; s_if.bcd_sgn = s;
      end
   endtask

   function automatic logic rd_busy(input bit uns);
      return uns ? u_if.busy : s_if.busy;
   endfunction
   function automatic logic rd_done(input bit uns);
      return uns ? u_if.done : s_if.done;
   endfunction
   function automatic logic [5:0] rd_bin(input bit uns);
      return uns ? u_if.bin : s_if.bin;
   endfunction
   function automatic logic rd_err(input bit uns);
      return uns ? u_if.err : s_if.err;
   endfunction

   task automatic applyStimulus(input bit uns, input logic [7:0] b, input logic [3:0] s, input string tag);
      @(negedge clk);
      drive(uns, 1'b1, b, s);
      @(posedge clk);
      #1;
      drive(uns, 1'b0, 8'($urandom), 4'($urandom));
      checkOutput({tag, "_busy_on"}, 32'(rd_busy(uns)), 32'd1);
      checkOutput({tag, "_done_low"}, 32'(rd_done(uns)), 32'd0);
   endtask

   task automatic waitDone(input bit uns, input logic [5:0] eb, input logic ee,
                           input string tag, input int inject);
      int  lat = -1;
      bit  busy_drop = 1'b0;
      for (int c = 1; c <= 20; c++) begin
         if (c == inject) begin
            @(negedge clk);
            drive(uns, 1'b1, 8'h05, 4'hF);
         end
         @(posedge clk);
         #1;
         if (c == inject) drive(uns, 1'b0, 8'h05, 4'hF);
         if (rd_done(uns)) begin
            lat = c;
            break;
         end
         if (!rd_busy(uns)) busy_drop = 1'b1;
      end
      checkOutput({tag, "_latency"}, 32'(lat), 32'd7);
      checkOutput({tag, "_busy_held"}, 32'(busy_drop), 32'd0);
      checkOutput({tag, "_busy_off"}, 32'(rd_busy(uns)), 32'd0);
      checkOutput({tag, "_bin"}, 32'(rd_bin(uns)), 32'(eb));
      checkOutput({tag, "_err"}, 32'(ee), 32'(ee));
      checkOutput({tag, "_err_val"}, 32'(rd_err(uns)), 32'(ee));
   endtask

   task automatic convModel(input bit uns, input logic [7:0] b, input logic [3:0] s, input string tag);
      logic [5:0] eb;
      logic       ee;
      model(uns, b, s, eb, ee);
      applyStimulus(uns, b, s, tag);
      waitDone(uns, eb, ee, tag, -1);
   endtask

   initial begin
      int done_seen;
      drive(1'b0, 1'b0, 8'h00, 4'hF);
      drive(1'b1, 1'b0, 8'h00, 4'hF);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_busy", 32'(s_if.busy), 32'd0);
      checkOutput("rst_done", 32'(s_if.done), 32'd0);
      checkOutput("rst_bin",  32'(s_if.bin),  32'd0);
      checkOutput("rst_err",  32'(s_if.err),  32'd0);
      @(negedge clk);
      rst = 1'b0;

      applyStimulus(1'b0, 8'h27, 4'hF, "p27");
      waitDone(1'b0, 6'b011011, 1'b0, "p27", -1);
      applyStimulus(1'b0, 8'h32, 4'hA, "n32");
      waitDone(1'b0, 6'b100000, 1'b0, "n32", -1);
      applyStimulus(1'b0, 8'h32, 4'hF, "p32");
`ifdef BCD2BIN_SAT_EN
      waitDone(1'b0, 6'b011111, 1'b1, "p32", -1);
`else
      waitDone(1'b0, 6'b000000, 1'b1, "p32", -1);
`endif
      applyStimulus(1'b0, 8'h1A, 4'hF, "bad1A");
      waitDone(1'b0, 6'b000000, 1'b1, "bad1A", -1);
      applyStimulus(1'b0, 8'h00, 4'hA, "negzero");
      waitDone(1'b0, 6'b000000, 1'b0, "negzero", -1);
      applyStimulus(1'b0, 8'h31, 4'hA, "n31");
      waitDone(1'b0, 6'b100001, 1'b0, "n31", -1);

      applyStimulus(1'b1, 8'h63, 4'hA, "u63");
      waitDone(1'b1, 6'b111111, 1'b0, "u63", -1);
      applyStimulus(1'b1, 8'h64, 4'hF, "u64");
`ifdef BCD2BIN_SAT_EN
      waitDone(1'b1, 6'b111111, 1'b1, "u64", -1);
`else
      waitDone(1'b1, 6'b000000, 1'b1, "u64", -1);
`endif

      applyStimulus(1'b0, 8'h27, 4'hF, "ignore");
      waitDone(1'b0, 6'b011011, 1'b0, "ignore", 3);
      applyStimulus(1'b0, 8'h05, 4'hF, "b2b");
      waitDone(1'b0, 6'b000101, 1'b0, "b2b", -1);

      applyStimulus(1'b0, 8'h27, 4'hF, "abort");
      repeat (3) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("abort_busy", 32'(s_if.busy), 32'd0);
      checkOutput("abort_done", 32'(s_if.done), 32'd0);
      checkOutput("abort_bin",  32'(s_if.bin),  32'd0);
      checkOutput("abort_err",  32'(s_if.err),  32'd0);
      @(negedge clk);
      rst = 1'b0;
      done_seen = 0;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk);
         #1;
         if (s_if.done) done_seen++;
      end
      checkOutput("abort_no_done", 32'(done_seen), 32'd0);
      applyStimulus(1'b0, 8'h19, 4'hA, "fresh");
      waitDone(1'b0, 6'b101101, 1'b0, "fresh", -1);

      for (int i = 0; i < 40; i++) begin
         bit         uns;
         logic [7:0] b;
         logic [3:0] s;
         uns = 1'($urandom);
         b   = {4'($urandom_range(0, 11)), 4'($urandom_range(0, 11))};
         case ($urandom_range(0, 2))
            0:       s = 4'hA;
            1:       s = 4'hF;
            default: s = 4'($urandom);
         endcase
         convModel(uns, b, s, $sformatf("rnd%0d", i));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
